rst_tag_codec: RTL and testbench
================================

Name: rst_tag_codec

Overview:
- Registered address codec for the register-status-table (RST) write/clear path.
- Decode half: turns a 5-bit write address plus enable into a 32-bit one-hot write-enable vector.
- Encode half: turns a 32-bit clear-request vector (one bit per RST entry whose tag matched the CDB) into a 5-bit entry index plus a clear-enable flag.
- Both halves are registered on the same clock.

Parameters:
- None. Widths are fixed: 5-bit address, 32 entries.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Waddr_rst  input  5  RST entry address to write
- Wen_rst  input  1  write enable for Waddr_rst
- Wen0_rst  output  32  registered one-hot write-enable vector
- wen1_rst  input  32  clear-request vector; bit k requests clear of entry k
- Addr  output  5  registered index of the selected clear request
- Clear_en  output  1  registered; 1 when Addr is valid (at least one request bit set)
- Multi_hit  output  1  registered; more than one bit of wen1_rst set (see Optional Feature)

Behaviour:
- All outputs are registers updated on the rising edge of clock. Latency is exactly 1 cycle from input to output; there are no combinational input-to-output paths.
- Reset (sampled at the edge while reset=1):
  - Wen0_rst=32'h0, Addr=5'd0, Clear_en=0, Multi_hit=0.
  - Reset overrides all inputs in that cycle.
  - Deasserting reset mid-operation: the first edge with reset=0 captures the current inputs normally.
- Decode:
  - Next Wen0_rst = Wen_rst ? (32'h1 << Waddr_rst) : 32'h0.
  - Exactly one bit is set when Wen_rst=1; all zero otherwise.
  - Waddr_rst is ignored when Wen_rst=0.
  - Every address 0..31 is legal; address 31 sets bit 31 only, with no wrap-around.
- Encode:
  - Next Clear_en = OR-reduction of wen1_rst.
  - Next Addr = index of the lowest-numbered set bit of wen1_rst (fixed priority, bit 0 highest).
  - wen1_rst=0 gives Addr=0 and Clear_en=0. Consumers must qualify Addr with Clear_en.
  - Only one entry is reported per cycle. Lower-priority requests are dropped unless the requester re-presents them in a later cycle; the block keeps no request queue.
- Simultaneous events: decode and encode are independent and both update every cycle. This block performs no write-versus-clear arbitration; the upstream logic masks wen1_rst with ~Wen0_rst.
- No other internal state exists.

Optional Feature:
- Macro: RST_CODEC_MULTIHIT_EN.
- Defined:
  - Next Multi_hit = 1 when two or more bits of wen1_rst are set; 0 otherwise.
  - Registered with the same 1-cycle latency as Addr.
  - Reset value is 0.
- Not defined: Multi_hit is tied to constant 0 and no population-count logic is built. The port is present in both builds.
- Addr and Clear_en behave identically in both builds.

Test Plan:
- Reset: assert reset with Wen_rst=1, Waddr_rst=5'd7, wen1_rst=32'hFFFF_FFFF -> after the edge, Wen0_rst=0, Addr=0, Clear_en=0, Multi_hit=0.
- Decode sweep: Wen_rst=1 with Waddr_rst=0..31 -> one cycle later Wen0_rst=1<<Waddr_rst (e.g. 5'd31 -> 32'h8000_0000). Wen_rst=0, Waddr_rst=5'd12 -> Wen0_rst=0.
- Encode single hit: wen1_rst=32'h0000_0400 -> next cycle Addr=10, Clear_en=1, Multi_hit=0. wen1_rst=0 -> Addr=0, Clear_en=0.
- Priority: wen1_rst=32'h8000_0030 -> Addr=4, Clear_en=1. With RST_CODEC_MULTIHIT_EN, Multi_hit=1; without it, Multi_hit=0.
- Concurrent: Wen_rst=1, Waddr_rst=3, wen1_rst=32'h0000_0001 in the same cycle -> Wen0_rst=32'h8, Addr=0, Clear_en=1 together.
- Back-to-back: change inputs every cycle for 100 random cycles -> each output equals the golden model of the previous cycle's inputs.

Source files
------------

// File: rtl/rst_tag_codec.sv
// Registered RST address codec: 5-to-32 one-hot write decode and 32-to-5 priority clear encode.
// Optional multi-hit flag built only when RST_CODEC_MULTIHIT_EN is defined.
module rst_tag_codec (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  Waddr_rst,
  input  logic        Wen_rst,
  output logic [31:0] Wen0_rst,
  input  logic [31:0] wen1_rst,
  output logic [4:0]  Addr,
  output logic        Clear_en,
  output logic        Multi_hit
);

  logic [31:0] w_wen0_next;
  logic [4:0]  w_addr_next;
  logic        w_clear_next;

  logic [31:0] r_wen0;
  logic [4:0]  r_addr;
  logic        r_clear_en;

  assign w_wen0_next  = Wen_rst ? (32'h1 << Waddr_rst) : 32'h0;
  assign w_clear_next = |wen1_rst;

  // Scan from the top down so the lowest set bit is the last one written and wins.
  always_comb begin
    // NOTE: default first so every path assigns w_addr_next; otherwise a latch is inferred.
    w_addr_next = 5'd0;
    for (int k = 31; k >= 0; k--) begin
      if (wen1_rst[k]) w_addr_next = k[4:0];
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for state so all registers sample pre-edge values together.
    if (reset) begin
      r_wen0     <= 32'h0;
      r_addr     <= 5'd0;
      r_clear_en <= 1'b0;
    end else begin
      r_wen0     <= w_wen0_next;
      r_addr     <= w_addr_next;
      r_clear_en <= w_clear_next;
    end
  end

  assign Wen0_rst = r_wen0;
  assign Addr     = r_addr;
  assign Clear_en = r_clear_en;

`ifdef RST_CODEC_MULTIHIT_EN
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  logic w_multi_next;
  logic r_multi_hit;

  assign w_multi_next = |(wen1_rst & (wen1_rst - 32'd1));

  always_ff @(posedge clock) begin
    if (reset) r_multi_hit <= 1'b0;
    else       r_multi_hit <= w_multi_next;
  end

  assign Multi_hit = r_multi_hit;
`else
  assign Multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_rst_tag_codec.sv
// Self-checking bench for rst_tag_codec: directed vectors plus a randomised back-to-back run
// compared against a behavioural model of the previous cycle's inputs.
module tb_rst_tag_codec;

  logic        clock;
  logic        reset;
  logic [4:0]  Waddr_rst;
  logic        Wen_rst;
  logic [31:0] Wen0_rst;
  logic [31:0] wen1_rst;
  logic [4:0]  Addr;
  logic        Clear_en;
  logic        Multi_hit;

  int checks = 0;
  int errors = 0;

  rst_tag_codec dut (
    .clock     (clock),
    .reset     (reset),
    .Waddr_rst (Waddr_rst),
    .Wen_rst   (Wen_rst),
    .Wen0_rst  (Wen0_rst),
    .wen1_rst  (wen1_rst),
    .Addr      (Addr),
    .Clear_en  (Clear_en),
    .Multi_hit (Multi_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural reference: upward scan for the first set bit, and a plain bit count.
  function automatic logic [4:0] model_addr(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i[4:0];
    return 5'd0;
  endfunction

  function automatic int model_count(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic model_multi(input logic [31:0] v);
`ifdef RST_CODEC_MULTIHIT_EN
    return model_count(v) >= 2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Wen_rst = 1'b1; Waddr_rst = 5'd7; wen1_rst = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (Wen0_rst !== 32'h0) begin errors++; $display("FAIL reset_wen0 got %h want %h", Wen0_rst, 32'h0); end
    checks++;
    if (Addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", Addr); end
    checks++;
    if (Clear_en !== 1'b0) begin errors++; $display("FAIL reset_clear_en got %b want 0", Clear_en); end
    checks++;
    if (Multi_hit !== 1'b0) begin errors++; $display("FAIL reset_multi_hit got %b want 0", Multi_hit); end
    reset = 1'b0; Wen_rst = 1'b0; wen1_rst = 32'h0;
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] exp;
    for (int a = 0; a < 32; a++) begin
      Wen_rst = 1'b1; Waddr_rst = a[4:0];
      tick();
      exp = 32'h0;
      exp[a] = 1'b1;
      checks++;
      if (Wen0_rst !== exp) begin errors++; $display("FAIL decode_addr%0d got %h want %h", a, Wen0_rst, exp); end
    end
    checks++;
    if (Wen0_rst !== 32'h8000_0000) begin errors++; $display("FAIL decode_top got %h want 80000000", Wen0_rst); end
    Wen_rst = 1'b0; Waddr_rst = 5'd12;
    tick();
    checks++;
    if (Wen0_rst !== 32'h0) begin errors++; $display("FAIL decode_disabled got %h want 0", Wen0_rst); end
  endtask

  task automatic test_encode();
    wen1_rst = 32'h0000_0400;
    tick();
    checks++;
    if (Addr !== 5'd10) begin errors++; $display("FAIL enc_single_addr got %0d want 10", Addr); end
    checks++;
    if (Clear_en !== 1'b1) begin errors++; $display("FAIL enc_single_clear got %b want 1", Clear_en); end
    checks++;
    if (Multi_hit !== 1'b0) begin errors++; $display("FAIL enc_single_multi got %b want 0", Multi_hit); end
    wen1_rst = 32'h0;
    tick();
    checks++;
    if (Addr !== 5'd0) begin errors++; $display("FAIL enc_none_addr got %0d want 0", Addr); end
    checks++;
    if (Clear_en !== 1'b0) begin errors++; $display("FAIL enc_none_clear got %b want 0", Clear_en); end
    wen1_rst = 32'h8000_0000;
    tick();
    checks++;
    if (Addr !== 5'd31 || Clear_en !== 1'b1) begin
      errors++; $display("FAIL enc_bit31 got addr %0d clr %b want 31 1", Addr, Clear_en);
    end
  endtask

  task automatic test_priority();
    logic exp_multi;
`ifdef RST_CODEC_MULTIHIT_EN
    exp_multi = 1'b1;
`else
    exp_multi = 1'b0;
`endif
    wen1_rst = 32'h8000_0030;
    tick();
    checks++;
    if (Addr !== 5'd4) begin errors++; $display("FAIL prio_addr got %0d want 4", Addr); end
    checks++;
    if (Clear_en !== 1'b1) begin errors++; $display("FAIL prio_clear got %b want 1", Clear_en); end
    checks++;
    if (Multi_hit !== exp_multi) begin errors++; $display("FAIL prio_multi got %b want %b", Multi_hit, exp_multi); end
    wen1_rst = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (Addr !== 5'd0 || Clear_en !== 1'b1) begin
      errors++; $display("FAIL prio_all got addr %0d clr %b want 0 1", Addr, Clear_en);
    end
    wen1_rst = 32'h0;
  endtask

  task automatic test_concurrent();
    Wen_rst = 1'b1; Waddr_rst = 5'd3; wen1_rst = 32'h0000_0001;
    tick();
    checks++;
    if (Wen0_rst !== 32'h8 || Addr !== 5'd0 || Clear_en !== 1'b1) begin
      errors++;
      $display("FAIL concurrent got wen0 %h addr %0d clr %b want 00000008 0 1", Wen0_rst, Addr, Clear_en);
    end
    Wen_rst = 1'b0; wen1_rst = 32'h0;
  endtask

  task automatic test_reset_release();
    Wen_rst = 1'b1; Waddr_rst = 5'd20; wen1_rst = 32'h0000_0300;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (Wen0_rst !== 32'h0 || Clear_en !== 1'b0 || Addr !== 5'd0) begin
      errors++;
      $display("FAIL midreset got wen0 %h addr %0d clr %b want 0 0 0", Wen0_rst, Addr, Clear_en);
    end
    reset = 1'b0; Waddr_rst = 5'd5; wen1_rst = 32'h0000_0300;
    tick();
    checks++;
    if (Wen0_rst !== 32'h20 || Addr !== 5'd8 || Clear_en !== 1'b1) begin
      errors++;
      $display("FAIL release got wen0 %h addr %0d clr %b want 00000020 8 1", Wen0_rst, Addr, Clear_en);
    end
    Wen_rst = 1'b0; wen1_rst = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_wen0;
    logic [4:0]  exp_addr;
    logic        exp_clr;
    logic        exp_multi;
    int          bad;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      Wen_rst   = 1'($urandom_range(0, 1));
      Waddr_rst = 5'($urandom_range(0, 31));
      case (c % 4)
        0: wen1_rst = 32'h0;
        1: wen1_rst = 32'h1 << $urandom_range(0, 31);
        default: wen1_rst = $urandom;
      endcase
      exp_wen0 = 32'h0;
      if (Wen_rst) exp_wen0[Waddr_rst] = 1'b1;
      exp_addr  = model_addr(wen1_rst);
      exp_clr   = model_count(wen1_rst) != 0;
      exp_multi = model_multi(wen1_rst);
      tick();
      checks++;
      if (Wen0_rst !== exp_wen0 || Addr !== exp_addr || Clear_en !== exp_clr || Multi_hit !== exp_multi) begin
        errors++;
        if (bad < 5)
          $display("FAIL b2b_cycle%0d got %h/%0d/%b/%b want %h/%0d/%b/%b", c,
                   Wen0_rst, Addr, Clear_en, Multi_hit, exp_wen0, exp_addr, exp_clr, exp_multi);
        bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; Wen_rst = 1'b0; Waddr_rst = 5'd0; wen1_rst = 32'h0;
    #1;
    test_reset();
    test_decode();
    test_encode();
    test_priority();
    test_concurrent();
    test_reset_release();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
